multi_countdown: RTL



---
 rtl/countdown_pkg.sv | 16 +
 rtl/countdown_channel.sv | 109 ++++++++++
 rtl/multi_countdown.sv | 57 +++++
 3 files changed

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and defaults for the multi-channel countdown bank.
//   chan_state_t     - per-channel FSM state (IDLE, RUN, HOLD)
//   DEFAULT_WIDTH    - default counter width per channel
//   DEFAULT_CHANNELS - default number of channels
package countdown_pkg;

  localparam int DEFAULT_WIDTH    = 7;
  localparam int DEFAULT_CHANNELS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } chan_state_t;

endpackage

// File: rtl/countdown_channel.sv
// countdown_channel: one down-counter channel with start-edge load, stop,
// pause/hold and a one-cycle done pulse on expiry.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN (adds reload_en).
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   tick_en       - shared decrement strobe
//   start         - start request, rising edge loads preset_value
//   stop          - abort (level), returns to IDLE with count 0
//   pause         - hold (level)
//   preset_value  - value loaded on a start edge
//   reload_en     - auto-reload select (macro only)
//   count_out     - registered current count
//   active        - registered, 1 in RUN or HOLD
//   done          - registered one-cycle expiry pulse
module countdown_channel
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_en,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] preset_value,
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  input  logic             reload_en,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic             active,
  output logic             done
);

  chan_state_t      state;
  logic             start_q;
  logic [WIDTH-1:0] preset_latch;
  logic             reload_sel;
  logic             reload;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  always_comb reload_sel = reload_en;
`else
  always_comb reload_sel = 1'b0;
`endif

  // A zero latch never reloads, so an expiry with it always ends in IDLE.
  always_comb reload = reload_sel && (preset_latch != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count_out    <= '0;
      preset_latch <= '0;
      start_q      <= 1'b0;
      active       <= 1'b0;
      done         <= 1'b0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      if (start && !start_q) begin
        count_out    <= preset_value;
        preset_latch <= preset_value;
        if (preset_value != '0) begin
          state  <= RUN;
          active <= 1'b1;
        end else begin
          state  <= IDLE;
          active <= 1'b0;
        end
      end else if (stop) begin
        state     <= IDLE;
        count_out <= '0;
        active    <= 1'b0;
      end else begin
        case (state)
          // HOLD releasing with a tick applies that tick, so RUN and HOLD
          // share the decrement path once pause is low.
          RUN, HOLD: begin
            if (pause) begin
              state <= HOLD;
            end else begin
              state <= RUN;
              if (tick_en) begin
                if (count_out > WIDTH'(1)) begin
                  count_out <= count_out - WIDTH'(1);
                end else begin
                  done <= 1'b1;
                  if (reload) begin
                    count_out <= preset_latch;
                  end else begin
                    count_out <= '0;
                    state     <= IDLE;
                    active    <= 1'b0;
                  end
                end
              end
            end
          end
          default: begin
            state  <= IDLE;
            active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_countdown.sv
// multi_countdown: bank of CHANNELS independent countdown channels.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN (adds reload_en).
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   tick_en       - shared decrement strobe
//   start/stop/pause - per-channel controls, one bit per channel
//   preset_value  - channel i at [i*WIDTH +: WIDTH]
//   reload_en     - per-channel auto-reload select (macro only)
//   count_out     - current counts, same packing as preset_value
//   active        - per-channel RUN/HOLD flag
//   done          - per-channel one-cycle expiry pulse
//   any_active    - OR of active
module multi_countdown
  import countdown_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick_en,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       pause,
  input  logic [CHANNELS*WIDTH-1:0] preset_value,
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  input  logic [CHANNELS-1:0]       reload_en,
`endif
  output logic [CHANNELS*WIDTH-1:0] count_out,
  output logic [CHANNELS-1:0]       active,
  output logic [CHANNELS-1:0]       done,
  output logic                      any_active
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    countdown_channel #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick_en      (tick_en),
      .start        (start[i]),
      .stop         (stop[i]),
      .pause        (pause[i]),
      .preset_value (preset_value[i*WIDTH +: WIDTH]),
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      .reload_en    (reload_en[i]),
`endif
      .count_out    (count_out[i*WIDTH +: WIDTH]),
      .active       (active[i]),
      .done         (done[i])
    );
  end

  always_comb any_active = |active;

endmodule
